seq_alu: RTL and testbench
==========================

# seq_alu

Parametrised, multi-cycle successor to the team's 4-bit combinational ALU. It keeps the same eight-opcode set and adds several things: configurable operand width, registered outputs, valid/ready handshakes on both sides, iterative multiply/divide, and status flags. It sits between an operand source (register file or test sequencer) and a result consumer. It accepts one operation at a time.

## Interface
Parameters:
- WIDTH, 8, operand width in bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation present on a/b/opcode.
- in_ready  out  1  block can accept; high only in IDLE and only while rst is low.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- opcode  in  3  000 ADD, 001 SUB, 010 MUL, 011 DIV, 100 AND, 101 OR, 110 XOR, 111 ROL.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes the result.
- result  out  2*WIDTH  registered result.
- zero  out  1  result == 0.
- carry  out  1  ADD carry-out, or SUB borrow; 0 for all other opcodes.
- div_by_zero  out  1  DIV issued with b == 0.

## Operation
- Accept: an operation is accepted when in_valid && in_ready at a rising edge. a, b and opcode are captured, so the inputs may change afterwards.
- State machine:
  - IDLE: on accept, a single-cycle op or DIV with b == 0 goes to DONE; MUL, or DIV with b != 0, goes to BUSY.
  - BUSY: runs the iteration counter from 0 to WIDTH-1; when count == WIDTH-1 it goes to DONE.
  - DONE: out_valid = 1; on out_ready goes to IDLE. No accept is possible in the same cycle.
- Result rules (all upper bits zero-filled unless stated):
  - ADD: result = a + b, WIDTH+1 bits; carry = bit WIDTH.
  - SUB: result[WIDTH-1:0] = a - b (mod 2^WIDTH); result[WIDTH] = borrow (a < b); carry = borrow.
  - MUL: full unsigned 2*WIDTH product, computed by shift-add, one partial product per cycle.
  - DIV: unsigned restoring division, one quotient bit per cycle. result = {remainder, quotient}: remainder in the upper WIDTH bits, quotient in the lower WIDTH bits.
  - DIV with b == 0: quotient = all ones, remainder = a, div_by_zero = 1.
  - AND/OR/XOR: bitwise on WIDTH bits.
  - ROL: a rotated left by 1, i.e. {a[WIDTH-2:0], a[WIDTH-1]}.
- Flags are computed from the final result. They are registered together with result and valid only while out_valid is high.

## Timing
- Reset values: state IDLE, in_ready = 0 while rst is high and 1 after release, out_valid 0, result 0, zero 0, carry 0, div_by_zero 0, counter 0.
- Latency, from the accept edge to the first cycle out_valid is high:
  - single-cycle ops and DIV by zero: 1 cycle;
  - MUL and DIV (b != 0): WIDTH+1 cycles.
- Throughput: at best one op per 2 cycles for single-cycle ops. A new accept is possible only in the cycle after the DONE→IDLE handoff.
- Backpressure: in DONE, result and flags are held stable for as long as out_ready stays low. in_ready stays low in BUSY and DONE.
- out_ready is ignored when out_valid is low. in_valid is ignored outside IDLE.
- Reset mid-operation (BUSY or DONE) aborts immediately: outputs go to their reset values, no result is emitted, and the partial state is discarded.
- Simultaneous in_valid and out_ready in DONE: the result is retired and the new op is not accepted; it must be held until in_ready is high.

## Structure
- Package alu_pkg holds:
  - opcode localparams (OP_ADD … OP_ROL);
  - the state encoding typedef (IDLE, BUSY, DONE);
  - a function that classifies an opcode as single-cycle or iterative.
- Sub-module alu_muldiv_iter (parameter WIDTH) implements the shift-add multiplier and the restoring divider:
  - shares one accumulator and one shifter;
  - interface: start, is_div, a, b, done, product_or_{rem,quot}.
- The top level contains the FSM, the operand capture registers, the single-cycle datapath, flag generation and the output registers.

## Test plan
All scenarios use WIDTH = 8.
- ADD a=200, b=100 → result 0x012C, carry 1, zero 0, out_valid 1 cycle after accept.
- SUB a=5, b=7 → result 0x01FE, carry 1. SUB a=9, b=9 → result 0x0000, zero 1, carry 0.
- MUL a=255, b=255 → result 0xFE01, out_valid exactly 9 cycles after accept. in_ready must be 0 throughout.
- DIV a=200, b=7 → result 0x041C (remainder 4, quotient 28) after 9 cycles.
- DIV a=0x55, b=0 → result 0x55FF, div_by_zero 1, after 1 cycle.
- Handshake and reset:
  - ROL a=0x81 → result 0x0003.
  - Holding out_ready low for 5 cycles keeps result and flags stable and in_ready 0.
  - Asserting rst in the 4th BUSY cycle of a MUL drives out_valid 0 and result 0 at once. The first op accepted after release completes correctly.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM state encoding and opcode classification shared by seq_alu
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_ROL = 3'd7;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t BUSY = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic logic is_iter(input logic [2:0] op);
        return op == OP_MUL || op == OP_DIV;
    endfunction
endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: shift-add multiplier and restoring divider sharing one accumulator
module alu_muldiv_iter #(parameter int WIDTH = 8) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 is_div_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   product_or_rem_quot_o
);
    localparam int CW = $clog2(WIDTH);
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] opd, hi, lo;
    logic [WIDTH:0] sum, shl, diff;
    logic [CW-1:0] cnt_q;
    logic run_q;
    // MUL: acc = {partial, multiplier} shifted right; DIV: acc = {remainder, dividend/quotient} shifted left
    always_comb begin
        opd = is_div_i ? b_i : a_i;
        hi = acc_q[2*WIDTH-1:WIDTH];
        lo = acc_q[WIDTH-1:0];
        sum = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
        shl = {hi, lo[WIDTH-1]};
        diff = shl - {1'b0, opd};
        acc_d = is_div_i ? {diff[WIDTH] ? shl[WIDTH-1:0] : diff[WIDTH-1:0], lo[WIDTH-2:0], ~diff[WIDTH]}
                         : {sum, lo[WIDTH-1:1]};
    end
    assign done_o = run_q && cnt_q == CW'(WIDTH - 1);
    assign product_or_rem_quot_o = acc_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start_i) begin
            acc_q <= {{WIDTH{1'b0}}, is_div_i ? a_i : b_i};
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            acc_q <= acc_d;
            cnt_q <= done_o ? '0 : cnt_q + 1'b1;
            run_q <= !done_o;
        end
    end
endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU with valid/ready handshakes, iterative MUL/DIV and status flags
module seq_alu import alu_pkg::*; #(parameter int WIDTH = 8) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [2:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero,
    output logic                 carry,
    output logic                 div_by_zero
);
    localparam int RW = 2 * WIDTH;
    state_t state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, ca, cb;
    logic [2:0] op_q, cop;
    logic [WIDTH:0] add_w, sub_w;
    logic [RW-1:0] sc_res, md_res, result_q, result_d;
    logic zero_q, carry_q, dbz_q, carry_d, dbz_d, iter, start, md_done, load;
    // live inputs in IDLE, captured operands once the op is in flight
    always_comb begin
        ca = state_q == IDLE ? a : a_q;
        cb = state_q == IDLE ? b : b_q;
        cop = state_q == IDLE ? opcode : op_q;
        add_w = {1'b0, ca} + {1'b0, cb};
        sub_w = {1'b0, ca} - {1'b0, cb};
        iter = is_iter(cop) && !(cop == OP_DIV && cb == '0);
        start = state_q == IDLE && in_valid && iter;
        sc_res = cop == OP_ADD ? RW'(add_w) :
                 cop == OP_SUB ? RW'(sub_w) :
                 cop == OP_AND ? RW'(ca & cb) :
                 cop == OP_OR  ? RW'(ca | cb) :
                 cop == OP_XOR ? RW'(ca ^ cb) :
                 cop == OP_ROL ? RW'({ca[WIDTH-2:0], ca[WIDTH-1]}) :
                                 {ca, {WIDTH{1'b1}}};
        result_d = state_q == BUSY ? md_res : sc_res;
        carry_d = (cop == OP_ADD && add_w[WIDTH]) || (cop == OP_SUB && sub_w[WIDTH]);
        dbz_d = state_q == IDLE && cop == OP_DIV;
        load = (state_q == IDLE && in_valid && !iter) || (state_q == BUSY && md_done);
        state_d = state_q == IDLE ? (in_valid ? (iter ? BUSY : DONE) : IDLE) :
                  state_q == BUSY ? (md_done ? DONE : BUSY) :
                                    (out_ready ? IDLE : DONE);
    end
    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk(clk),
        .rst(rst),
        .start_i(start),
        .is_div_i(cop == OP_DIV),
        .a_i(ca),
        .b_i(cb),
        .done_o(md_done),
        .product_or_rem_quot_o(md_res)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q <= '0;
            b_q <= '0;
            op_q <= '0;
            result_q <= '0;
            zero_q <= 1'b0;
            carry_q <= 1'b0;
            dbz_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                a_q <= a;
                b_q <= b;
                op_q <= opcode;
            end
            if (load) begin
                result_q <= result_d;
                zero_q <= result_d == '0;
                carry_q <= carry_d;
                dbz_q <= dbz_d;
            end
        end
    end
    assign in_ready = state_q == IDLE && !rst;
    assign out_valid = state_q == DONE;
    assign result = result_q;
    assign zero = zero_q;
    assign carry = carry_q;
    assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vectors with hand-computed results for seq_alu at WIDTH = 8
module tb_seq_alu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic in_ready, out_valid, zero, carry, div_by_zero;
    logic [7:0] a = '0, b = '0;
    logic [2:0] opcode = '0;
    logic [15:0] result;
    int n_chk = 0, n_fail = 0;

    seq_alu #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .carry(carry), .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("in_ready_wait", in_ready, 1);
    endtask

    task automatic do_op(input string tag, input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb,
                         input int exp_lat, input logic [15:0] exp_res, input logic ez, input logic ec,
                         input logic ed, input int hold);
        int lat;
        logic ir_bad, bp_bad;
        wait_ready();
        opcode = op; a = va; b = vb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); opcode = 3'($urandom);
        lat = 1;
        ir_bad = 1'b0;
        while (!out_valid && lat < 40) begin
            ir_bad |= in_ready;
            @(posedge clk); #1;
            lat++;
        end
        ir_bad |= in_ready;
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_res"}, result, exp_res);
        chk({tag, "_zero"}, zero, ez);
        chk({tag, "_carry"}, carry, ec);
        chk({tag, "_dbz"}, div_by_zero, ed);
        chk({tag, "_in_ready_low"}, ir_bad, 0);
        bp_bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            bp_bad |= !out_valid || in_ready || result !== exp_res || zero !== ez || carry !== ec || div_by_zero !== ed;
        end
        if (hold > 0) chk({tag, "_backpressure"}, bp_bad, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_retired"}, out_valid, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_flags", {zero, carry, div_by_zero}, 0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", in_ready, 1);

        do_op("add", 3'd0, 8'd200, 8'd100, 1, 16'h012C, 0, 1, 0, 0);
        do_op("add_wrap", 3'd0, 8'd255, 8'd1, 1, 16'h0100, 0, 1, 0, 0);
        do_op("add_zero", 3'd0, 8'd0, 8'd0, 1, 16'h0000, 1, 0, 0, 0);
        do_op("sub_borrow", 3'd1, 8'd5, 8'd7, 1, 16'h01FE, 0, 1, 0, 0);
        do_op("sub_eq", 3'd1, 8'd9, 8'd9, 1, 16'h0000, 1, 0, 0, 0);
        do_op("mul_max", 3'd2, 8'd255, 8'd255, 9, 16'hFE01, 0, 0, 0, 0);
        do_op("mul_zero", 3'd2, 8'd0, 8'd77, 9, 16'h0000, 1, 0, 0, 0);
        do_op("div", 3'd3, 8'd200, 8'd7, 9, 16'h041C, 0, 0, 0, 0);
        do_op("div_small", 3'd3, 8'd3, 8'd10, 9, 16'h0300, 0, 0, 0, 0);
        do_op("div_by_zero", 3'd3, 8'h55, 8'd0, 1, 16'h55FF, 0, 0, 1, 0);
        do_op("and_bp", 3'd4, 8'hF0, 8'h3C, 1, 16'h0030, 0, 0, 0, 5);
        do_op("xor", 3'd6, 8'hAA, 8'hFF, 1, 16'h0055, 0, 0, 0, 0);
        do_op("rol", 3'd7, 8'h81, 8'h00, 1, 16'h0003, 0, 0, 0, 0);

        // new op offered while the previous result retires: must wait for IDLE
        wait_ready();
        opcode = 3'd5; a = 8'h0F; b = 8'h30; in_valid = 1'b1;
        @(posedge clk); #1;
        opcode = 3'd0; a = 8'd1; b = 8'd2; out_ready = 1'b1;
        chk("or_res", result, 16'h003F);
        chk("or_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("overlap_retired", out_valid, 0);
        chk("overlap_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("overlap_accept_valid", out_valid, 1);
        chk("overlap_accept_res", result, 16'h0003);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // reset in the 4th BUSY cycle of a MUL
        wait_ready();
        opcode = 3'd2; a = 8'd255; b = 8'd255; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy_ready", in_ready, 0);
        rst = 1'b1;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_result", result, 0);
        chk("abort_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        do_op("mul_after_rst", 3'd2, 8'd12, 8'd13, 9, 16'h009C, 0, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
